// File: rtl/alu_packet_engine.sv
// Packet responder: parses {opcode, 0x00, len_lo, len_hi} headers from the RX byte
// stream and answers with echoed payload or a 32-bit ADD/MUL/DIV result, LSB first.
module alu_packet_engine #(
  parameter logic [7:0] OPCODE_ECHO = 8'hEC,
  parameter logic [7:0] OPCODE_ADD  = 8'hAD,
  parameter logic [7:0] OPCODE_MUL  = 8'h88,
  parameter logic [7:0] OPCODE_DIV  = 8'hD1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       error_o
);

  typedef enum logic [3:0] {
    S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_ECHO, S_OPND, S_DIVRUN, S_DIVFIX, S_RESULT, S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] word_q, word_d;
  logic [1:0]  word_cnt_q, word_cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] rem_q, rem_d;
  logic        neg_q, neg_d;
  logic        dvz_q, dvz_d;
  logic [4:0]  div_cnt_q, div_cnt_d;
  logic [1:0]  res_idx_q, res_idx_d;
  logic [7:0]  echo_data_q, echo_data_d;
  logic        echo_full_q, echo_full_d;

  logic        rx_fire, tx_fire, is_math, last_word;
  logic [15:0] len_full, pay_cnt;
  logic [31:0] word_full, dd_fin, dv_fin, dd_mag, dv_mag;
  logic [32:0] rem_sh, diff;

  always_comb begin
    case (state_q)
      S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_OPND, S_DRAIN: rx_ready_o = 1'b1;
      S_ECHO:  rx_ready_o = !echo_full_q;
      default: rx_ready_o = 1'b0;
    endcase
  end

  assign tx_valid_o = (state_q == S_RESULT) || echo_full_q;
  assign tx_data_o  = (state_q == S_RESULT) ? acc_q[{res_idx_q, 3'b000} +: 8] : echo_data_q;
  assign busy_o     = (state_q != S_HDR0);
  assign rx_fire    = rx_valid_i && rx_ready_o;
  assign tx_fire    = tx_valid_o && tx_ready_i;

  assign is_math   = (op_q == OPCODE_ADD) || (op_q == OPCODE_MUL) || (op_q == OPCODE_DIV);
  assign len_full  = {rx_data_i, len_lo_q};
  assign pay_cnt   = (len_full >= 16'd4) ? len_full - 16'd4 : 16'd0;
  assign word_full = {rx_data_i, word_q};
  assign last_word = (byte_idx_q == 2'd3);

  // Operands as they stand once the final payload byte lands, so the divider can load directly.
  assign dd_fin = (last_word && word_cnt_q == 2'd0) ? word_full : acc_q;
  assign dv_fin = (last_word && word_cnt_q == 2'd1) ? word_full : dvsr_q;
  assign dd_mag = dd_fin[31] ? -dd_fin : dd_fin;
  assign dv_mag = dv_fin[31] ? -dv_fin : dv_fin;

  assign rem_sh = {rem_q, acc_q[31]};
  assign diff   = rem_sh - {1'b0, dvsr_q};

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_lo_d    = len_lo_q;
    cnt_d       = cnt_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    word_cnt_d  = word_cnt_q;
    acc_d       = acc_q;
    dvsr_d      = dvsr_q;
    rem_d       = rem_q;
    neg_d       = neg_q;
    dvz_d       = dvz_q;
    div_cnt_d   = div_cnt_q;
    res_idx_d   = res_idx_q;
    echo_data_d = echo_data_q;
    echo_full_d = echo_full_q;
    error_o     = 1'b0;
    case (state_q)
      S_HDR0: if (rx_fire) begin
        op_d    = rx_data_i;
        state_d = S_HDR1;
      end
      S_HDR1: if (rx_fire) state_d = S_HDR2;
      S_HDR2: if (rx_fire) begin
        len_lo_d = rx_data_i;
        state_d  = S_HDR3;
      end
      S_HDR3: if (rx_fire) begin
        cnt_d      = pay_cnt;
        byte_idx_d = 2'd0;
        word_cnt_d = 2'd0;
        res_idx_d  = 2'd0;
        acc_d      = (op_q == OPCODE_MUL) ? 32'd1 : 32'd0;
        dvsr_d     = 32'd0;
        if (op_q == OPCODE_ECHO) begin
          state_d = (pay_cnt == 16'd0) ? S_HDR0 : S_ECHO;
        end else if (is_math) begin
          state_d = (pay_cnt == 16'd0) ? S_RESULT : S_OPND;
        end else begin
          error_o = 1'b1;
          state_d = (pay_cnt == 16'd0) ? S_HDR0 : S_DRAIN;
        end
      end
      S_ECHO: begin
        if (rx_fire) begin
          echo_data_d = rx_data_i;
          echo_full_d = 1'b1;
          cnt_d       = cnt_q - 16'd1;
        end
        if (tx_fire) begin
          echo_full_d = 1'b0;
          if (cnt_q == 16'd0) state_d = S_HDR0;
        end
      end
      S_OPND: if (rx_fire) begin
        cnt_d      = cnt_q - 16'd1;
        byte_idx_d = byte_idx_q + 2'd1;
        word_d     = word_full[31:8];
        if (last_word) begin
          if (word_cnt_q != 2'd2) word_cnt_d = word_cnt_q + 2'd1;
          if (op_q == OPCODE_ADD)      acc_d = acc_q + word_full;
          else if (op_q == OPCODE_MUL) acc_d = acc_q * word_full;
          else if (word_cnt_q == 2'd0) acc_d = word_full;
          else if (word_cnt_q == 2'd1) dvsr_d = word_full;
        end
        if (cnt_q == 16'd1) begin
          if (op_q == OPCODE_DIV) begin
            acc_d     = dd_mag;
            dvsr_d    = dv_mag;
            rem_d     = 32'd0;
            neg_d     = dd_fin[31] ^ dv_fin[31];
            dvz_d     = (dv_fin == 32'd0);
            div_cnt_d = 5'd0;
            state_d   = S_DIVRUN;
          end else begin
            state_d = S_RESULT;
          end
        end
      end
      // Restoring divide: acc_q shifts out dividend bits and shifts in quotient bits.
      S_DIVRUN: begin
        if (!diff[32]) begin
          rem_d = diff[31:0];
          acc_d = {acc_q[30:0], 1'b1};
        end else begin
          rem_d = rem_sh[31:0];
          acc_d = {acc_q[30:0], 1'b0};
        end
        div_cnt_d = div_cnt_q + 5'd1;
        if (div_cnt_q == 5'd31) state_d = S_DIVFIX;
      end
      S_DIVFIX: begin
        if (dvz_q)      acc_d = 32'hFFFF_FFFF;
        else if (neg_q) acc_d = -acc_q;
        res_idx_d = 2'd0;
        state_d   = S_RESULT;
      end
      S_RESULT: if (tx_fire) begin
        res_idx_d = res_idx_q + 2'd1;
        if (res_idx_q == 2'd3) state_d = S_HDR0;
      end
      S_DRAIN: if (rx_fire) begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = S_HDR0;
      end
      default: state_d = S_HDR0;
    endcase
  end

  // NOTE: reset is synchronous here; registers use <= so all update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_HDR0;
      op_q        <= 8'd0;
      len_lo_q    <= 8'd0;
      cnt_q       <= 16'd0;
      byte_idx_q  <= 2'd0;
      word_q      <= 24'd0;
      word_cnt_q  <= 2'd0;
      acc_q       <= 32'd0;
      dvsr_q      <= 32'd0;
      rem_q       <= 32'd0;
      neg_q       <= 1'b0;
      dvz_q       <= 1'b0;
      div_cnt_q   <= 5'd0;
      res_idx_q   <= 2'd0;
      echo_data_q <= 8'd0;
      echo_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_lo_q    <= len_lo_d;
      cnt_q       <= cnt_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      word_cnt_q  <= word_cnt_d;
      acc_q       <= acc_d;
      dvsr_q      <= dvsr_d;
      rem_q       <= rem_d;
      neg_q       <= neg_d;
      dvz_q       <= dvz_d;
      div_cnt_q   <= div_cnt_d;
      res_idx_q   <= res_idx_d;
      echo_data_q <= echo_data_d;
      echo_full_q <= echo_full_d;
    end
  end

endmodule
